// File: rtl/gpio_v2_pkg.sv
// ============================================================================
// gpio_v2_pkg : register offsets, pin mode encoding and byte-lane helper
// Revision    : 1.0
// ============================================================================
`default_nettype none

package gpio_v2_pkg;

  localparam int MAX_GPIO     = 32;
  localparam int DEBOUNCE_CNT = 3;

  localparam logic [4:0] OFF_CTRL0      = 5'h00;
  localparam logic [4:0] OFF_CTRL1      = 5'h04;
  localparam logic [4:0] OFF_DATA       = 5'h08;
  localparam logic [4:0] OFF_SET        = 5'h0C;
  localparam logic [4:0] OFF_CLR        = 5'h10;
  localparam logic [4:0] OFF_RISE_EN    = 5'h14;
  localparam logic [4:0] OFF_FALL_EN    = 5'h18;
  localparam logic [4:0] OFF_INT_STATUS = 5'h1C;

  typedef enum logic [1:0] {
    HIZ  = 2'd0,
    OUT  = 2'd1,
    IN   = 2'd2,
    RSVD = 2'd3
  } gpio_mode_e;

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{sel[b]}};
    end
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gpio_v2_in_filter.sv
// ============================================================================
// gpio_v2_in_filter : per-pin input synchroniser with optional debounce
//                     (debounce built only when GPIO_DEBOUNCE_EN is defined)
// Revision          : 1.0
// ============================================================================
`default_nettype none

module gpio_v2_in_filter
  import gpio_v2_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic pin_i,
  output logic val_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   w_sync;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign w_sync = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  logic       filt_q;
  logic       filt_d;
  logic [1:0] cnt_q;
  logic [1:0] cnt_d;

  // Any tick that agrees with the current filtered level restarts the count.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (tick_i) begin
      if (w_sync == filt_q) begin
        cnt_d = '0;
      end else if (cnt_q == 2'(DEBOUNCE_CNT - 1)) begin
        filt_d = w_sync;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign val_o = filt_q;
`else
  logic unused_tick;
  assign unused_tick = tick_i;
  assign val_o       = w_sync;
`endif

endmodule

`default_nettype wire

// File: rtl/gpio_v2.sv
// ============================================================================
// gpio_v2  : GPIO peripheral with sync inputs, set/clear and edge interrupts
//            optional input debounce enabled by defining GPIO_DEBOUNCE_EN
// Revision : 1.0
// ============================================================================
`default_nettype none

module gpio_v2
  import gpio_v2_pkg::*;
#(
  parameter int GPIO_NUM     = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_DIV = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         addr_i,
  input  logic [31:0]         data_i,
  input  logic [3:0]          sel_i,
  input  logic                we_i,
  input  logic                req_valid_i,
  output logic [31:0]         data_o,
  input  logic [GPIO_NUM-1:0] io_pin_i,
  output logic [GPIO_NUM-1:0] io_out_o,
  output logic [GPIO_NUM-1:0] io_oe_o,
  output logic                irq_o
);

  localparam int MW = 2 * GPIO_NUM;

  logic [MW-1:0]       mode_q,    mode_d;
  logic [GPIO_NUM-1:0] out_q,     out_d;
  logic [GPIO_NUM-1:0] rise_en_q, rise_en_d;
  logic [GPIO_NUM-1:0] fall_en_q, fall_en_d;
  logic [GPIO_NUM-1:0] int_q,     int_d;
  logic [GPIO_NUM-1:0] prev_q,    prev_d;
  logic                irq_q,     irq_d;
  logic [31:0]         rdata_q,   rdata_d;

  logic [4:0]          w_off;
  logic                w_wr;
  logic                w_rd;
  logic [31:0]         w_lane;
  logic [MW-1:0]       w_mode_mask;
  logic [MW-1:0]       w_mode_data;
  logic [GPIO_NUM-1:0] w_lane_p;
  logic [GPIO_NUM-1:0] w_bits_p;
  logic [GPIO_NUM-1:0] w_w1c;
  logic [GPIO_NUM-1:0] w_is_out;
  logic [GPIO_NUM-1:0] w_is_in;
  logic [GPIO_NUM-1:0] w_pin_val;
  logic [GPIO_NUM-1:0] w_rise;
  logic [GPIO_NUM-1:0] w_fall;
  logic [GPIO_NUM-1:0] w_edge_set;
  logic [63:0]         w_mode_ext;
  logic [31:0]         w_rdata;
  logic                w_tick;
  logic [26:0]         unused_addr;

  assign w_off       = addr_i[4:0];
  assign unused_addr = addr_i[31:5];
  assign w_wr        = req_valid_i & we_i;
  assign w_rd        = req_valid_i & ~we_i;
  assign w_lane      = lane_mask(sel_i);
  assign w_lane_p    = GPIO_NUM'(w_lane);
  assign w_bits_p    = GPIO_NUM'(data_i) & w_lane_p;
  assign w_w1c       = (w_wr && (w_off == OFF_INT_STATUS)) ? w_bits_p : '0;

  // CTRL0 and CTRL1 form one contiguous 2-bit-per-pin field; truncation drops
  // the bits of unimplemented pins so they are never stored.
  assign w_mode_mask = MW'({{32{w_wr && (w_off == OFF_CTRL1)}} & w_lane,
                            {32{w_wr && (w_off == OFF_CTRL0)}} & w_lane});
  assign w_mode_data = MW'({data_i, data_i});
  assign w_mode_ext  = 64'(mode_q);

`ifdef GPIO_DEBOUNCE_EN
  logic [31:0] presc_q, presc_d;

  always_comb begin
    w_tick  = (presc_q == 32'(DEBOUNCE_DIV - 1));
    presc_d = w_tick ? '0 : presc_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  logic [31:0] unused_div;
  assign unused_div = 32'(DEBOUNCE_DIV);
  assign w_tick     = 1'b0;
`endif

  for (genvar i = 0; i < GPIO_NUM; i++) begin : g_pin
    gpio_mode_e pin_mode;
    assign pin_mode    = gpio_mode_e'(mode_q[2*i +: 2]);
    assign w_is_out[i] = (pin_mode == OUT);
    assign w_is_in[i]  = (pin_mode == IN);

    gpio_v2_in_filter #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_filter (
      .clk   (clk),
      .rst   (rst),
      .tick_i(w_tick),
      .pin_i (io_pin_i[i]),
      .val_o (w_pin_val[i])
    );
  end

  // prev always follows the input so re-entering input mode sees no stale edge.
  assign w_rise     = w_pin_val & ~prev_q & w_is_in;
  assign w_fall     = ~w_pin_val & prev_q & w_is_in;
  assign w_edge_set = (w_rise & rise_en_q) | (w_fall & fall_en_q);

  always_comb begin
    mode_d    = (mode_q & ~w_mode_mask) | (w_mode_data & w_mode_mask);
    out_d     = out_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    if (w_wr) begin
      case (w_off)
        OFF_DATA:    out_d     = (out_q & ~w_lane_p) | w_bits_p;
        OFF_SET:     out_d     = out_q | w_bits_p;
        OFF_CLR:     out_d     = out_q & ~w_bits_p;
        OFF_RISE_EN: rise_en_d = (rise_en_q & ~w_lane_p) | w_bits_p;
        OFF_FALL_EN: fall_en_d = (fall_en_q & ~w_lane_p) | w_bits_p;
        default:     ;
      endcase
    end
    int_d   = (int_q & ~w_w1c) | w_edge_set;
    prev_d  = w_pin_val;
    irq_d   = |(int_q & (rise_en_q | fall_en_q));
    rdata_d = w_rd ? w_rdata : '0;
  end

  always_comb begin
    w_rdata = '0;
    case (w_off)
      OFF_CTRL0:      w_rdata = w_mode_ext[31:0];
      OFF_CTRL1:      w_rdata = w_mode_ext[63:32];
      OFF_DATA:       w_rdata = 32'((out_q & w_is_out) | (w_pin_val & w_is_in));
      OFF_RISE_EN:    w_rdata = 32'(rise_en_q);
      OFF_FALL_EN:    w_rdata = 32'(fall_en_q);
      OFF_INT_STATUS: w_rdata = 32'(int_q);
      default:        w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= '0;
      out_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      int_q     <= '0;
      prev_q    <= '0;
      irq_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      mode_q    <= mode_d;
      out_q     <= out_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      int_q     <= int_d;
      prev_q    <= prev_d;
      irq_q     <= irq_d;
      rdata_q   <= rdata_d;
    end
  end

  assign io_oe_o  = w_is_out;
  assign io_out_o = out_q & w_is_out;
  assign irq_o    = irq_q;
  assign data_o   = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_gpio_v2.sv
// ============================================================================
// tb_gpio_v2 : self-checking bench for gpio_v2 (table vectors + scoreboard)
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tb_gpio_v2;
  import gpio_v2_pkg::*;

  localparam int GN = 8;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   addr_i = '0;
  logic [31:0]   data_i = '0;
  logic [3:0]    sel_i = '0;
  logic          we_i = 1'b0;
  logic          req_valid_i = 1'b0;
  logic [31:0]   data_o;
  logic [GN-1:0] io_pin_i = '0;
  logic [GN-1:0] io_out_o;
  logic [GN-1:0] io_oe_o;
  logic          irq_o;

  gpio_v2 #(.GPIO_NUM(GN), .SYNC_STAGES(SS), .DEBOUNCE_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .addr_i     (addr_i),
    .data_i     (data_i),
    .sel_i      (sel_i),
    .we_i       (we_i),
    .req_valid_i(req_valid_i),
    .data_o     (data_o),
    .io_pin_i   (io_pin_i),
    .io_out_o   (io_out_o),
    .io_oe_o    (io_oe_o),
    .irq_o      (irq_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [4:0]  off;
    logic [31:0] wd;
    logic [3:0]  sel;
    logic [31:0] rd;
    logic [7:0]  oe;
    logic [7:0]  out;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    bit          cio;
    logic [7:0]  oe;
    logic [7:0]  out;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: retire the previous expectation, then drive and queue the new one.
  task automatic step(input bit rv, input bit we, input logic [4:0] off, input logic [31:0] wd,
                      input logic [3:0] sel, input logic [31:0] rd, input bit cio,
                      input logic [7:0] oe, input logic [7:0] out);
    exp_t e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("data_o", data_o, e.data);
      if (e.cio) begin
        chk("io_oe_o", 32'(io_oe_o), 32'(e.oe));
        chk("io_out_o", 32'(io_out_o), 32'(e.out));
      end
    end
    req_valid_i = rv;
    we_i        = we;
    addr_i      = {27'h0, off};
    data_i      = wd;
    sel_i       = sel;
    e.data      = (rv && !we) ? rd : 32'h0;
    e.cio       = cio;
    e.oe        = oe;
    e.out       = out;
    exp_q.push_back(e);
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] wd);
    step(1'b1, 1'b1, off, wd, 4'hF, 32'h0, 1'b0, 8'h0, 8'h0);
  endtask

  task automatic rd(input logic [4:0] off, input logic [31:0] exp);
    step(1'b1, 1'b0, off, 32'h0, 4'h0, exp, 1'b0, 8'h0, 8'h0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'h0, 32'h0, 4'h0, 32'h0, 1'b0, 8'h0, 8'h0);
  endtask

  function automatic vec_t v(input bit we, input logic [4:0] off, input logic [31:0] wd,
                             input logic [3:0] sel, input logic [31:0] rd,
                             input logic [7:0] oe, input logic [7:0] out);
    vec_t t;
    t.we = we; t.off = off; t.wd = wd; t.sel = sel; t.rd = rd; t.oe = oe; t.out = out;
    return t;
  endfunction

  initial begin
    // reset values and every register reading zero
    tbl.push_back(v(0, OFF_CTRL0,      0, 0, 32'h0, 8'h00, 8'h00));
    tbl.push_back(v(0, OFF_CTRL1,      0, 0, 32'h0, 8'h00, 8'h00));
    tbl.push_back(v(0, OFF_DATA,       0, 0, 32'h0, 8'h00, 8'h00));
    tbl.push_back(v(0, OFF_SET,        0, 0, 32'h0, 8'h00, 8'h00));
    tbl.push_back(v(0, OFF_CLR,        0, 0, 32'h0, 8'h00, 8'h00));
    tbl.push_back(v(0, OFF_RISE_EN,    0, 0, 32'h0, 8'h00, 8'h00));
    tbl.push_back(v(0, OFF_FALL_EN,    0, 0, 32'h0, 8'h00, 8'h00));
    tbl.push_back(v(0, OFF_INT_STATUS, 0, 0, 32'h0, 8'h00, 8'h00));
    // output mode, DATA/SET/CLR
    tbl.push_back(v(1, OFF_CTRL0, 32'h1,  4'hF, 0,     8'h01, 8'h00));
    tbl.push_back(v(1, OFF_DATA,  32'h1,  4'hF, 0,     8'h01, 8'h01));
    tbl.push_back(v(0, OFF_DATA,  0,      0,    32'h1, 8'h01, 8'h01));
    tbl.push_back(v(1, OFF_CLR,   32'h1,  4'hF, 0,     8'h01, 8'h00));
    tbl.push_back(v(0, OFF_DATA,  0,      0,    32'h0, 8'h01, 8'h00));
    tbl.push_back(v(1, OFF_SET,   32'h1,  4'hF, 0,     8'h01, 8'h01));
    tbl.push_back(v(0, OFF_SET,   0,      0,    32'h0, 8'h01, 8'h01));
    tbl.push_back(v(0, OFF_CTRL0, 0,      0,    32'h1, 8'h01, 8'h01));
    tbl.push_back(v(1, OFF_CLR,   32'h1,  4'hF, 0,     8'h01, 8'h00));
    // preload DATA while hi-Z, then switch pins 4-7 to output
    tbl.push_back(v(1, OFF_DATA,  32'hF0, 4'hF, 0,     8'h01, 8'h00));
    tbl.push_back(v(1, OFF_CTRL0, 32'h5501, 4'hF, 0,   8'hF1, 8'hF0));
    tbl.push_back(v(0, OFF_DATA,  0,      0,    32'hF0, 8'hF1, 8'hF0));
    // byte lanes
    tbl.push_back(v(1, OFF_DATA,  32'hFF00, 4'h2, 0,   8'hF1, 8'hF0));
    tbl.push_back(v(0, OFF_DATA,  0,      0,    32'hF0, 8'hF1, 8'hF0));
    tbl.push_back(v(1, OFF_CLR,   32'hFFFF_FFFF, 4'h0, 0, 8'hF1, 8'hF0));
    tbl.push_back(v(1, OFF_CLR,   32'h30, 4'hF, 0,     8'hF1, 8'hC0));
    tbl.push_back(v(0, OFF_DATA,  0,      0,    32'hC0, 8'hF1, 8'hC0));
    tbl.push_back(v(1, OFF_CTRL0, 32'hAAAA_AAAA, 4'h1, 0, 8'hF0, 8'hC0));
    tbl.push_back(v(0, OFF_CTRL0, 0,      0,    32'h55AA, 8'hF0, 8'hC0));
    tbl.push_back(v(0, OFF_DATA,  0,      0,    32'hC0, 8'hF0, 8'hC0));
    // reserved mode behaves as hi-Z
    tbl.push_back(v(1, OFF_CTRL0, 32'hC000, 4'hF, 0,   8'h00, 8'h00));
    tbl.push_back(v(0, OFF_DATA,  0,      0,    32'h0, 8'h00, 8'h00));
    tbl.push_back(v(1, OFF_CTRL0, 32'h4000, 4'hF, 0,   8'h80, 8'h80));
    tbl.push_back(v(0, OFF_DATA,  0,      0,    32'h80, 8'h80, 8'h80));
    tbl.push_back(v(1, OFF_CTRL0, 32'h0,  4'hF, 0,     8'h00, 8'h00));
    tbl.push_back(v(1, OFF_CTRL0, 32'hAAAA_AAAA, 4'h1, 0, 8'h00, 8'h00));
    tbl.push_back(v(0, OFF_CTRL0, 0,      0,    32'hAA, 8'h00, 8'h00));
    // unimplemented pins read zero
    tbl.push_back(v(1, OFF_CTRL1, 32'hFFFF_FFFF, 4'hF, 0, 8'h00, 8'h00));
    tbl.push_back(v(0, OFF_CTRL1, 0,      0,    32'h0, 8'h00, 8'h00));
    tbl.push_back(v(1, OFF_RISE_EN, 32'hFFFF_FFFF, 4'hF, 0, 8'h00, 8'h00));
    tbl.push_back(v(0, OFF_RISE_EN, 0,    0,    32'hFF, 8'h00, 8'h00));
    tbl.push_back(v(1, OFF_FALL_EN, 32'h5A5A, 4'h1, 0, 8'h00, 8'h00));
    tbl.push_back(v(0, OFF_FALL_EN, 0,    0,    32'h5A, 8'h00, 8'h00));
    tbl.push_back(v(1, OFF_INT_STATUS, 32'hFF, 4'hF, 0, 8'h00, 8'h00));
    tbl.push_back(v(0, OFF_INT_STATUS, 0, 0,    32'h0, 8'h00, 8'h00));
    tbl.push_back(v(1, OFF_RISE_EN, 32'h0, 4'hF, 0,    8'h00, 8'h00));
    tbl.push_back(v(1, OFF_FALL_EN, 32'h0, 4'hF, 0,    8'h00, 8'h00));
    tbl.push_back(v(1, OFF_CTRL0,   32'h0, 4'hF, 0,    8'h00, 8'h00));
    tbl.push_back(v(1, OFF_DATA,    32'h0, 4'hF, 0,    8'h00, 8'h00));

    repeat (2) @(negedge clk);
    chk("rst_data_o", data_o, 32'h0);
    chk("rst_io_oe_o", 32'(io_oe_o), 32'h0);
    chk("rst_io_out_o", 32'(io_out_o), 32'h0);
    chk("rst_irq_o", 32'(irq_o), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      step(1'b1, tbl[i].we, tbl[i].off, tbl[i].wd, tbl[i].sel, tbl[i].rd,
           1'b1, tbl[i].oe, tbl[i].out);
    end

`ifdef GPIO_DEBOUNCE_EN
    wr(OFF_CTRL0, 32'h2);
    wr(OFF_RISE_EN, 32'h1);
    wr(OFF_FALL_EN, 32'h1);
    io_pin_i[0] = 1'b1;
    repeat (8) idle();
    io_pin_i[0] = 1'b0;
    repeat (12) idle();
    rd(OFF_DATA, 32'h0);
    rd(OFF_INT_STATUS, 32'h0);
    chk("glitch_irq", 32'(irq_o), 32'h0);
    io_pin_i[0] = 1'b1;
    repeat (24) idle();
    rd(OFF_DATA, 32'h1);
    rd(OFF_INT_STATUS, 32'h1);
    idle();
    chk("stable_irq", 32'(irq_o), 32'h1);
`else
    // rising edge on pin 3: INT_STATUS after SS+1 edges, irq one edge later
    wr(OFF_CTRL0, 32'h80);
    wr(OFF_RISE_EN, 32'h8);
    idle();
    io_pin_i[3] = 1'b1;
    for (int k = 1; k <= SS + 2; k++) begin
      rd(OFF_INT_STATUS, (k >= SS + 1) ? 32'h8 : 32'h0);
      chk("rise_irq", 32'(irq_o), (k >= SS + 2) ? 32'h1 : 32'h0);
    end
    rd(OFF_DATA, 32'h8);
    wr(OFF_INT_STATUS, 32'h8);
    idle();
    rd(OFF_INT_STATUS, 32'h0);
    chk("w1c_irq", 32'(irq_o), 32'h0);

    // falling edge coinciding with W1C of the same bit
    wr(OFF_FALL_EN, 32'h8);
    io_pin_i[3] = 1'b0;
    for (int k = 1; k <= SS + 2; k++) begin
      if (k == SS)          wr(OFF_INT_STATUS, 32'h8);
      else if (k == SS + 1) rd(OFF_INT_STATUS, 32'h8);
      else                  idle();
    end
    chk("fall_irq", 32'(irq_o), 32'h1);

    // asynchronous reset in the middle of activity
    wr(OFF_CTRL0, 32'h81);
    wr(OFF_DATA, 32'h1);
    rd(OFF_CTRL0, 32'h81);
    @(posedge clk);
    #2;
    begin
      exp_t e;
      e = exp_q.pop_front();
      chk("pre_rst_data_o", data_o, e.data);
    end
    chk("pre_rst_oe", 32'(io_oe_o), 32'h1);
    chk("pre_rst_irq", 32'(irq_o), 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_data_o", data_o, 32'h0);
    chk("mid_rst_oe", 32'(io_oe_o), 32'h0);
    chk("mid_rst_out", 32'(io_out_o), 32'h0);
    chk("mid_rst_irq", 32'(irq_o), 32'h0);
    req_valid_i = 1'b0;
    we_i = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd(OFF_CTRL0, 32'h0);
    rd(OFF_INT_STATUS, 32'h0);

    // input -> output -> input mode changes produce no edge
    wr(OFF_CTRL0, 32'h80);
    wr(OFF_RISE_EN, 32'h8);
    wr(OFF_FALL_EN, 32'h8);
    io_pin_i[3] = 1'b1;
    repeat (4) idle();
    rd(OFF_INT_STATUS, 32'h8);
    wr(OFF_INT_STATUS, 32'h8);
    wr(OFF_CTRL0, 32'h40);
    io_pin_i[3] = 1'b0;
    repeat (4) idle();
    rd(OFF_INT_STATUS, 32'h0);
    wr(OFF_CTRL0, 32'h80);
    repeat (3) idle();
    rd(OFF_INT_STATUS, 32'h0);
    rd(OFF_DATA, 32'h0);
    idle();
    chk("mode_irq", 32'(irq_o), 32'h0);
`endif

    idle();
    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gpio_v2.md
Name: gpio_v2

Overview:
- Parametrised successor GPIO peripheral on the core's simple peripheral bus (addr/data/sel/we/req_valid, registered read data).
- Supports 1..32 pins, each with a 2-bit mode: high-Z, output or input.
- Adds input synchronisers, atomic set/clear of output data, and per-pin rising/falling-edge interrupt capture with a level interrupt output to the interrupt controller.

Parameters:
- GPIO_NUM, 16, number of implemented pins (1..32).
- SYNC_STAGES, 2, input synchroniser depth (2..4).
- DEBOUNCE_DIV, 1000, clk cycles per debounce sample tick. Used only with GPIO_DEBOUNCE_EN.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset: asynchronous, active-high.
- addr_i  input  32  byte address. Offset decode uses addr_i[4:0].
- data_i  input  32  write data.
- sel_i  input  4  byte-lane write enables.
- we_i  input  1  1 = write, 0 = read.
- req_valid_i  input  1  request strobe, one cycle per access.
- data_o  output  32  read data, registered.
- io_pin_i  input  GPIO_NUM  raw pad inputs (asynchronous).
- io_out_o  output  GPIO_NUM  pad output values.
- io_oe_o  output  GPIO_NUM  pad output enables.
- irq_o  output  1  level interrupt: OR of (INT_STATUS & (RISE_EN|FALL_EN)).

Behaviour:
- Register map (offset, reset value 0 for all):
  - 0x00 CTRL0: modes of pins 0-15, 2 bits each.
  - 0x04 CTRL1: modes of pins 16-31.
  - 0x08 DATA.
  - 0x0C SET: write-1-set of the output register; reads 0.
  - 0x10 CLR: write-1-clear of the output register; reads 0.
  - 0x14 RISE_EN.
  - 0x18 FALL_EN.
  - 0x1C INT_STATUS: write-1-clear.
- Mode encoding:
  - 0 = high-Z.
  - 1 = output.
  - 2 = input.
  - 3 = reserved, behaves as high-Z.
- All writes honour sel_i per byte lane. Bits for pins >= GPIO_NUM are not stored and read 0.
- Outputs:
  - io_oe_o[n] = (mode[n] == 1).
  - io_out_o[n] = out_reg[n] when mode[n] == 1, else 0.
  - Combinational from registers; they change the cycle after the write.
- DATA write updates out_reg regardless of mode. This allows preloading before switching a pin to output.
- DATA read, per bit:
  - Output pin: out_reg.
  - Input pin: synchronised value.
  - High-Z or reserved pin: 0.
- Synchroniser: SYNC_STAGES flops per pin, reset 0. Input latency is SYNC_STAGES cycles to the sync value.
- Edge detect:
  - A prev register holds the last sync value.
  - rise = sync & ~prev; fall = ~sync & prev.
  - Detection is active only for pins in input mode.
  - INT_STATUS[n] is set on (rise & RISE_EN[n]) | (fall & FALL_EN[n]).
- Simultaneous edge set and W1C of the same bit: set wins, and the bit stays 1.
- irq_o is asserted the cycle after INT_STATUS updates. It is held until cleared or until the enables are cleared.
- Read timing:
  - data_o is valid the cycle after req_valid_i with we_i = 0.
  - data_o is 0 in every cycle with no read.
  - Unmapped offsets read 0.
  - No wait states; a new request may follow every cycle.
- Reset asserted mid-operation: every register, synchroniser, prev flop and data_o clears immediately, and irq_o drops asynchronously.
- Mode change from input to output: no edge is generated. The prev register keeps tracking sync, but detection is gated.

Optional Feature:
- Macro: GPIO_DEBOUNCE_EN.
- Defined:
  - A shared prescaler counter wraps every DEBOUNCE_DIV cycles and emits a one-cycle tick.
  - Each input pin's filtered value changes only after 3 consecutive ticks sample the same new sync value. A 2-bit per-pin counter resets on mismatch.
  - Edge detect and DATA reads use the filtered value.
  - The prescaler and filters reset to 0.
- Undefined: the filtered value equals the sync value; no prescaler or filter logic is present.

Decomposition:
- Package gpio_v2_pkg:
  - Register offset constants.
  - gpio_mode_e enum: HIZ = 0, OUT = 1, IN = 2, RSVD = 3.
  - Constants MAX_GPIO = 32 and DEBOUNCE_CNT = 3.
- Sub-module gpio_v2_in_filter (per-pin synchroniser plus optional debounce):
  - Parameters: SYNC_STAGES.
  - Ports: clk, rst, tick_i, pin_i, val_o.
  - Instantiated GPIO_NUM times via generate.
- The top level holds the register file, edge detect, read mux and prescaler.

Test Plan:
- Reset, then read all offsets -> data_o = 0 for each. io_oe_o = 0, io_out_o = 0, irq_o = 0.
- Write CTRL0 = 0x1 and DATA = 0x1, then SET = 0x1 and CLR = 0x1 -> io_oe_o[0] = 1 and io_out_o[0] = 1. After CLR, io_out_o[0] = 0. Reading SET returns 0.
- Pin 3 in input mode, RISE_EN = 0x8, drive io_pin_i[3] 0->1 -> INT_STATUS = 0x8 exactly SYNC_STAGES+1 cycles later. irq_o = 1 the cycle after. W1C 0x8 clears both.
- Falling edge on pin 3 in the same cycle as a W1C of bit 3, with FALL_EN = 0x8 -> INT_STATUS[3] remains 1.
- Byte-lane write CTRL0 = 0xAAAA_AAAA with sel_i = 0x1 -> CTRL0 reads 0x0000_00AA. With GPIO_NUM = 4, CTRL1 reads 0 after a write of 0xFFFF_FFFF.
- With GPIO_DEBOUNCE_EN and DEBOUNCE_DIV = 4: a 2-tick glitch on pin 0 -> no DATA change and no interrupt. A 3-tick-stable level -> DATA[0] changes.
